morty_lsu_wb: RTL and testbench
===============================

Name: morty_lsu_wb

Overview:
- Parametrised, registered load/store unit for the MEM stage.
- Replaces the combinational Wishbone drive with a Wishbone classic master FSM.
- Adds byte-lane steering and sign/zero extension for 32- or 64-bit data paths, plus misalignment detection, a bus timeout, and precise exception reporting.
- Sits between the EX/MEM pipeline register and the data bus; stalls the pipeline until the access completes.

Parameters:
- DW, 32: data bus width; legal values 32 or 64. SEL width = DW/8. OFS = log2(DW/8).
- AW, 32: address width.
- TIMEOUT, 16: BUS-state cycles without ack/err before an access fault is forced; range 1..255.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- req_valid_i  in  1  load/store request present; held stable while stall_o=1
- req_we_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  RISC-V funct3 access size/sign
- req_addr_i  in  AW  byte address (ALU result)
- req_wdata_i  in  DW  store data (rs2)
- stall_o  out  1  hold the pipeline
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rdata_o  out  DW  extended load data
- exc_o  out  1  exception with rsp_valid_o
- exc_code_o  out  4  mcause code
- exc_addr_o  out  AW  faulting address (mtval)
- wbm_adr_o  out  AW  address, aligned to DW
- wbm_dat_o  out  DW  write data
- wbm_sel_o  out  DW/8  byte selects
- wbm_cyc_o  out  1  cycle
- wbm_stb_o  out  1  strobe
- wbm_we_o  out  1  write enable
- wbm_dat_i  in  DW  read data
- wbm_ack_i  in  1  acknowledge
- wbm_err_i  in  1  bus error

Behaviour:
- Reset values: all registered outputs 0; state IDLE; timeout counter 0. Reset is asynchronous and drops cyc/stb mid-access; any pending response is discarded.
- States:
  - IDLE: when req_valid_i=1 the request is decoded.
    - Illegal size goes to DONE with exc code 2: funct3=011 or 110 when DW=32; any store with funct3[2]=1; funct3=111.
    - Misaligned address (addr mod size != 0; sizes 1/2/4/8) goes to DONE with exc code 4 (load) or 6 (store). No bus cycle is issued.
    - Otherwise register adr/dat/sel/we, assert cyc=stb=1, clear the counter, go to BUS.
  - BUS: cyc/stb/adr/dat/sel/we held constant.
    - wbm_err_i=1 (takes priority over ack): exc code 5 (load) or 7 (store).
    - wbm_ack_i=1: capture load data.
    - Counter reaches TIMEOUT-1 with neither ack nor err: treat as err.
    - Each of these deasserts cyc/stb on the same edge and goes to DONE. Otherwise the counter increments.
  - DONE: rsp_valid_o=1 for exactly one cycle; exc_o/exc_code_o/exc_addr_o (= req address) valid. Next state is IDLE.
- stall_o: combinational, equals req_valid_i & (state != DONE). It is 0 when req_valid_i=0.
- Latency:
  - Zero-wait-state bus: request in cycle T, BUS in T+1, ack in T+1, DONE in T+2. stall_o is high in T and T+1.
  - Misaligned or illegal request: DONE in T+1.
- Byte lanes (o = addr[OFS-1:0]):
  - wbm_adr_o = addr with the low OFS bits cleared.
  - wbm_sel_o = size mask (1, 3, 0xF, 0xFF) << o.
  - wbm_dat_o = req_wdata_i << 8*o.
- Load data: shift = wbm_dat_i >> 8*o, then extend:
  - 000/001/010/011: sign-extend byte/half/word/dword.
  - 100/101/110: zero-extend.
  - rsp_rdata_o = 0 for stores and on exceptions.
- Back-to-back requests: the request seen in IDLE the cycle after DONE is a new request, since the pipeline advanced at DONE.
- Late or stray wbm_ack_i/wbm_err_i outside BUS is ignored.

Test Plan:
- DW=32, LH addr 0x1002, wbm_dat_i=0x8001_1234 ack in BUS cycle 1 -> sel=0xC, adr=0x1000, rsp_rdata_o=0xFFFF_8001, rsp_valid_o pulses at T+2, stall_o high exactly 2 cycles.
- DW=32, SB addr 0x2003, wdata=0x0000_00AB, ack after 3 wait states -> wbm_dat_o=0xAB00_0000, sel=0x8, we=1, cyc held 4 cycles, exc_o=0.
- LW addr 0x3001 -> no cyc asserted, DONE at T+1, exc_code_o=4, exc_addr_o=0x3001; same with SW -> exc_code_o=6.
- TIMEOUT=4, no ack -> cyc drops after 4 BUS cycles, exc_code_o=5; next cycle with ack=err=1 together -> err wins, code 5/7.
- DW=64, LWU addr 0x4004, wbm_dat_i=0xDEAD_BEEF_0000_0001 -> sel=0xF0, rsp_rdata_o=0x0000_0000_DEAD_BEEF; LD on DW=32 -> exc_code_o=2, no bus cycle.
- rst_i asserted during BUS with cyc=1 -> cyc/stb/rsp_valid_o go 0 immediately; the next request starts cleanly from IDLE.

Source files
------------

// File: rtl/morty_lsu_wb.sv
// MEM-stage load/store unit driving a Wishbone classic master.
// Handles byte-lane steering, load extension, misalignment/illegal-size traps,
// bus errors and a per-access timeout, and stalls the pipeline until done.
module morty_lsu_wb #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [DW-1:0]   req_wdata_i,
  output logic            stall_o,
  output logic            rsp_valid_o,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            exc_o,
  output logic [3:0]      exc_code_o,
  output logic [AW-1:0]   exc_addr_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i
);

  localparam int unsigned SW  = DW / 8;
  localparam int unsigned OFS = $clog2(SW);
  localparam int unsigned CW  = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    f3_q, f3_d;
  logic [AW-1:0] addr_q, addr_d;

  logic [AW-1:0] adr_d;
  logic [DW-1:0] dat_d;
  logic [SW-1:0] sel_d;
  logic          we_d, cyc_d, stb_d;
  logic          rv_d, exc_d;
  logic [3:0]    code_d;
  logic [AW-1:0] eaddr_d;
  logic [DW-1:0] rdata_d;

  logic          illegal_c, misal_c;
  logic [OFS-1:0] req_off;
  logic [SW-1:0] req_mask;

  logic [OFS-1:0] ld_off;
  logic [DW-1:0] ld_shift, ld_mask, ld_data;
  logic          ld_sbit;
  logic          timeout_c;

  // Stall the pipeline while a request is present and not yet completing.
  assign stall_o = req_valid_i & (state_q != DONE);

  // Decode the incoming request: legality, alignment and lane mask.
  always_comb begin
    req_off   = req_addr_i[OFS-1:0];
    illegal_c = (req_funct3_i == 3'b111) ||
                (req_we_i && req_funct3_i[2]) ||
                ((DW == 32) && ((req_funct3_i == 3'b011) || (req_funct3_i == 3'b110)));
    case (req_funct3_i[1:0])
      2'b00: begin
        misal_c  = 1'b0;
        req_mask = SW'(1);
      end
      2'b01: begin
        misal_c  = req_addr_i[0];
        req_mask = SW'(2'b11);
      end
      2'b10: begin
        misal_c  = |req_addr_i[1:0];
        req_mask = SW'(4'hF);
      end
      default: begin
        misal_c  = |req_addr_i[2:0];
        req_mask = SW'(8'hFF);
      end
    endcase
  end

  // Shift the returned lane down and sign/zero-extend it to the access size.
  always_comb begin
    ld_off   = addr_q[OFS-1:0];
    ld_shift = wbm_dat_i >> {ld_off, 3'b000};
    case (f3_q[1:0])
      2'b00: begin
        ld_mask = DW'(8'hFF);
        ld_sbit = ld_shift[7];
      end
      2'b01: begin
        ld_mask = DW'(16'hFFFF);
        ld_sbit = ld_shift[15];
      end
      2'b10: begin
        ld_mask = DW'(32'hFFFF_FFFF);
        ld_sbit = ld_shift[31];
      end
      default: begin
        ld_mask = '1;
        ld_sbit = ld_shift[DW-1];
      end
    endcase
    ld_data = (ld_shift & ld_mask) | ((ld_sbit && !f3_q[2]) ? ~ld_mask : '0);
  end

  assign timeout_c = (cnt_q == CW'(TIMEOUT - 1));

  // Next-state and next-output logic for the bus master FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    adr_d   = wbm_adr_o;
    dat_d   = wbm_dat_o;
    sel_d   = wbm_sel_o;
    we_d    = wbm_we_o;
    cyc_d   = wbm_cyc_o;
    stb_d   = wbm_stb_o;
    rv_d    = 1'b0;
    exc_d   = 1'b0;
    code_d  = exc_code_o;
    eaddr_d = exc_addr_o;
    rdata_d = rsp_rdata_o;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          f3_d    = req_funct3_i;
          addr_d  = req_addr_i;
          eaddr_d = req_addr_i;
          if (illegal_c || misal_c) begin
            state_d = DONE;
            rv_d    = 1'b1;
            exc_d   = 1'b1;
            rdata_d = '0;
            code_d  = illegal_c ? 4'd2 : (req_we_i ? 4'd6 : 4'd4);
          end else begin
            adr_d   = req_addr_i & ~AW'(SW - 1);
            dat_d   = req_wdata_i << {req_off, 3'b000};
            sel_d   = req_mask << req_off;
            we_d    = req_we_i;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            cnt_d   = '0;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (wbm_err_i || (!wbm_ack_i && timeout_c)) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = DONE;
          rv_d    = 1'b1;
          exc_d   = 1'b1;
          code_d  = wbm_we_o ? 4'd7 : 4'd5;
          rdata_d = '0;
        end else if (wbm_ack_i) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = DONE;
          rv_d    = 1'b1;
          code_d  = 4'd0;
          rdata_d = wbm_we_o ? '0 : ld_data;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      f3_q        <= '0;
      addr_q      <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
      wbm_we_o    <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      rsp_valid_o <= 1'b0;
      exc_o       <= 1'b0;
      exc_code_o  <= '0;
      exc_addr_o  <= '0;
      rsp_rdata_o <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wbm_adr_o   <= adr_d;
      wbm_dat_o   <= dat_d;
      wbm_sel_o   <= sel_d;
      wbm_we_o    <= we_d;
      wbm_cyc_o   <= cyc_d;
      wbm_stb_o   <= stb_d;
      rsp_valid_o <= rv_d;
      exc_o       <= exc_d;
      exc_code_o  <= code_d;
      exc_addr_o  <= eaddr_d;
      rsp_rdata_o <= rdata_d;
    end
  end

endmodule

// File: tb/tb_morty_lsu_wb.sv
// Bench for morty_lsu_wb: a 32-bit and a 64-bit instance share stimulus,
// each with its own request-valid; idle instance sees stray acks/errs.
module tb_morty_lsu_wb;

  localparam int unsigned TO0 = 4;
  localparam int unsigned TO1 = 6;

  logic        clk, rst;
  logic        v0, v1, we, ack, err;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [63:0] wdata, bdat;

  logic        s0, rv0, exc0, cyc0, stb0, wwe0;
  logic [31:0] rd0, ea0, adr0, dat0;
  logic [3:0]  code0, sel0;
  logic        s1, rv1, exc1, cyc1, stb1, wwe1;
  logic [63:0] rd1, dat1;
  logic [31:0] ea1, adr1;
  logic [3:0]  code1;
  logic [7:0]  sel1;

  int cur;
  logic        o_stall, o_rv, o_exc, o_cyc, o_stb, o_we;
  logic [63:0] o_rd, o_dat;
  logic [31:0] o_ea, o_adr;
  logic [3:0]  o_code;
  logic [7:0]  o_sel;

  int checks = 0;
  int errors = 0;

  morty_lsu_wb #(.DW(32), .AW(32), .TIMEOUT(TO0)) u32 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v0), .req_we_i(we), .req_funct3_i(f3),
    .req_addr_i(addr), .req_wdata_i(wdata[31:0]), .stall_o(s0), .rsp_valid_o(rv0),
    .rsp_rdata_o(rd0), .exc_o(exc0), .exc_code_o(code0), .exc_addr_o(ea0),
    .wbm_adr_o(adr0), .wbm_dat_o(dat0), .wbm_sel_o(sel0), .wbm_cyc_o(cyc0),
    .wbm_stb_o(stb0), .wbm_we_o(wwe0), .wbm_dat_i(bdat[31:0]), .wbm_ack_i(ack),
    .wbm_err_i(err));

  morty_lsu_wb #(.DW(64), .AW(32), .TIMEOUT(TO1)) u64 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v1), .req_we_i(we), .req_funct3_i(f3),
    .req_addr_i(addr), .req_wdata_i(wdata), .stall_o(s1), .rsp_valid_o(rv1),
    .rsp_rdata_o(rd1), .exc_o(exc1), .exc_code_o(code1), .exc_addr_o(ea1),
    .wbm_adr_o(adr1), .wbm_dat_o(dat1), .wbm_sel_o(sel1), .wbm_cyc_o(cyc1),
    .wbm_stb_o(stb1), .wbm_we_o(wwe1), .wbm_dat_i(bdat), .wbm_ack_i(ack),
    .wbm_err_i(err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe whichever instance the current transaction targets.
  always_comb begin
    if (cur == 0) begin
      o_stall = s0; o_rv = rv0; o_exc = exc0; o_cyc = cyc0; o_stb = stb0; o_we = wwe0;
      o_rd = {32'h0, rd0}; o_dat = {32'h0, dat0}; o_ea = ea0; o_adr = adr0;
      o_code = code0; o_sel = {4'h0, sel0};
    end else begin
      o_stall = s1; o_rv = rv1; o_exc = exc1; o_cyc = cyc1; o_stb = stb1; o_we = wwe1;
      o_rd = rd1; o_dat = dat1; o_ea = ea1; o_adr = adr1;
      o_code = code1; o_sel = sel1;
    end
  end

  typedef struct {
    int          which;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wd, bd;
    int          waits, mode;   // mode 0 ack, 1 err, 2 silent, 3 ack+err
    bit          exc;
    logic [3:0]  code;
    logic [63:0] rd;
    logic [7:0]  sel;
    logic [31:0] adr;
    logic [63:0] dat;
    int          lat, cycn;
  } vec_t;

  function automatic vec_t mk(int which, bit twe, logic [2:0] tf3, logic [31:0] ta,
                              logic [63:0] wd, logic [63:0] bd, int waits, int mode,
                              bit ex, logic [3:0] code, logic [63:0] rd, logic [7:0] sel,
                              logic [31:0] adr, logic [63:0] dat, int lat, int cycn);
    vec_t e;
    e.which = which; e.we = twe; e.f3 = tf3; e.addr = ta; e.wd = wd; e.bd = bd;
    e.waits = waits; e.mode = mode; e.exc = ex; e.code = code; e.rd = rd; e.sel = sel;
    e.adr = adr; e.dat = dat; e.lat = lat; e.cycn = cycn;
    return e;
  endfunction

  // Reference: derive the expected outcome straight from the access rules.
  function automatic vec_t model(int which, bit twe, logic [2:0] tf3, logic [31:0] ta,
                                 logic [63:0] wd, logic [63:0] bd, int waits, int mode);
    vec_t e;
    int dw, to, nb, size, off, bits;
    bit illegal, resp;
    logic [63:0] v, dwm, lm;
    e = mk(which, twe, tf3, ta, wd, bd, waits, mode, 0, 0, 0, 0, 0, 0, 1, 0);
    dw   = (which != 0) ? 64 : 32;
    to   = (which != 0) ? int'(TO1) : int'(TO0);
    nb   = dw / 8;
    dwm  = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    size = 1 << tf3[1:0];
    // LD/LWU only exist on the 64-bit path; stores have no unsigned forms.
    illegal = (tf3 == 3'b111) || (twe && tf3[2]) ||
              ((dw == 32) && (size == 8 || tf3 == 3'b110));
    if (illegal) begin
      e.exc = 1; e.code = 4'd2;
    end else if ((ta % size) != 0) begin
      e.exc = 1; e.code = twe ? 4'd6 : 4'd4;
    end else begin
      off    = int'(ta % nb);
      e.adr  = ta - off;
      e.sel  = 8'(((1 << size) - 1) << off);
      e.dat  = ((wd & dwm) << (8 * off)) & dwm;
      resp   = (mode != 2) && (waits < to);
      e.cycn = resp ? waits + 1 : to;
      e.lat  = e.cycn + 1;
      if (!resp || mode == 1 || mode == 3) begin
        e.exc = 1; e.code = twe ? 4'd7 : 4'd5;
      end else if (!twe) begin
        bits = 8 * size;
        v = (bd & dwm) >> (8 * off);
        if (bits < 64) begin
          lm = (64'd1 << bits) - 64'd1;
          v  = v & lm;
          if (!tf3[2] && v[bits-1]) v = v - (64'd1 << bits);
        end
        e.rd = v & dwm;
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  bit          obs_done, obs_chg, obs_exc, obs_we;
  int          obs_lat, obs_stall, obs_cyc;
  logic [3:0]  obs_code;
  logic [31:0] obs_ea, obs_adr;
  logic [63:0] obs_rd, obs_dat;
  logic [7:0]  obs_sel;

  // Issue one request, act as the bus slave, and record what the unit did.
  task automatic run_txn(input vec_t e);
    int bus_n;
    bit first;
    @(negedge clk);
    cur = e.which; we = e.we; f3 = e.f3; addr = e.addr; wdata = e.wd;
    if (e.which == 0) v0 = 1'b1; else v1 = 1'b1;
    obs_done = 0; obs_chg = 0; obs_stall = 0; obs_cyc = 0; obs_lat = -1;
    bus_n = 0; first = 1;
    for (int c = 0; c < 40 && !obs_done; c++) begin
      #1;
      if (o_rv) begin
        obs_done = 1; obs_lat = c; obs_exc = o_exc; obs_code = o_code;
        obs_ea = o_ea; obs_rd = o_rd;
      end
      if (o_stall) obs_stall++;
      ack = 1'b0; err = 1'b0;
      bdat = {$urandom, $urandom};
      if (o_cyc) begin
        obs_cyc++;
        if (first) begin
          obs_adr = o_adr; obs_sel = o_sel; obs_dat = o_dat; obs_we = o_we;
        end else if (o_adr !== obs_adr || o_sel !== obs_sel || o_dat !== obs_dat ||
                     o_we !== obs_we) begin
          obs_chg = 1;
        end
        if (o_stb !== 1'b1) obs_chg = 1;
        first = 0;
        if (bus_n == e.waits) begin
          case (e.mode)
            0: begin ack = 1'b1; bdat = e.bd; end
            1: err = 1'b1;
            3: begin ack = 1'b1; err = 1'b1; bdat = e.bd; end
            default: ;
          endcase
        end
        bus_n++;
      end
      if (!obs_done) @(negedge clk);
    end
    v0 = 1'b0; v1 = 1'b0; ack = 1'b0; err = 1'b0;
  endtask

  task automatic check_vec(input string tag, input vec_t e);
    chk({tag, " done"}, 64'(obs_done), 64'd1);
    if (obs_done) begin
      chk({tag, " latency"}, 64'(obs_lat), 64'(e.lat));
      chk({tag, " stall_cycles"}, 64'(obs_stall), 64'(e.lat));
      chk({tag, " cyc_cycles"}, 64'(obs_cyc), 64'(e.cycn));
      chk({tag, " exc"}, 64'(obs_exc), 64'(e.exc));
      chk({tag, " rdata"}, obs_rd, e.rd);
      if (e.exc) begin
        chk({tag, " exc_code"}, 64'(obs_code), 64'(e.code));
        chk({tag, " exc_addr"}, 64'(obs_ea), 64'(e.addr));
      end
      if (e.cycn > 0) begin
        chk({tag, " adr"}, 64'(obs_adr), 64'(e.adr));
        chk({tag, " sel"}, 64'(obs_sel), 64'(e.sel));
        chk({tag, " dat"}, obs_dat, e.dat);
        chk({tag, " we"}, 64'(obs_we), 64'(e.we));
        chk({tag, " bus_stable"}, 64'(obs_chg), 64'd0);
      end
    end
  endtask

  vec_t vecs[$];
  vec_t rv;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; v0 = 0; v1 = 0; we = 0; ack = 0; err = 0; f3 = 0; addr = 0;
    wdata = 0; bdat = 0; cur = 0;

    // which we f3 addr wdata busdat waits mode | exc code rdata sel adr dat lat cyc
    vecs.push_back(mk(0,0,3'b001,32'h1002,64'h0,64'h8001_1234,0,0, 0,0,64'hFFFF_8001,8'hC,32'h1000,64'h0,2,1));
    vecs.push_back(mk(0,1,3'b000,32'h2003,64'hAB,64'h0,3,0, 0,0,64'h0,8'h8,32'h2000,64'hAB00_0000,5,4));
    vecs.push_back(mk(0,0,3'b010,32'h3001,64'h0,64'h0,0,0, 1,4,64'h0,8'h0,32'h0,64'h0,1,0));
    vecs.push_back(mk(0,1,3'b010,32'h3001,64'h1111,64'h0,0,0, 1,6,64'h0,8'h0,32'h0,64'h0,1,0));
    vecs.push_back(mk(0,0,3'b010,32'h3000,64'h0,64'h0,0,2, 1,5,64'h0,8'hF,32'h3000,64'h0,5,4));
    vecs.push_back(mk(0,0,3'b010,32'h3004,64'h0,64'h5555,0,3, 1,5,64'h0,8'hF,32'h3004,64'h0,2,1));
    vecs.push_back(mk(0,1,3'b010,32'h3008,64'hCAFE_F00D,64'h0,0,3, 1,7,64'h0,8'hF,32'h3008,64'hCAFE_F00D,2,1));
    vecs.push_back(mk(1,0,3'b110,32'h4004,64'h0,64'hDEAD_BEEF_0000_0001,0,0, 0,0,64'h0000_0000_DEAD_BEEF,8'hF0,32'h4000,64'h0,2,1));
    vecs.push_back(mk(0,0,3'b011,32'h4000,64'h0,64'h0,0,0, 1,2,64'h0,8'h0,32'h0,64'h0,1,0));
    vecs.push_back(mk(1,0,3'b011,32'h4008,64'h0,64'h8000_0000_0000_0001,1,0, 0,0,64'h8000_0000_0000_0001,8'hFF,32'h4008,64'h0,3,2));
    vecs.push_back(mk(0,0,3'b111,32'h4000,64'h0,64'h0,0,0, 1,2,64'h0,8'h0,32'h0,64'h0,1,0));
    vecs.push_back(mk(0,1,3'b100,32'h4000,64'h0,64'h0,0,0, 1,2,64'h0,8'h0,32'h0,64'h0,1,0));
    vecs.push_back(mk(1,1,3'b011,32'h4004,64'h0,64'h0,0,0, 1,6,64'h0,8'h0,32'h0,64'h0,1,0));
    vecs.push_back(mk(0,0,3'b100,32'h5001,64'h0,64'h0000_8000,0,0, 0,0,64'h80,8'h2,32'h5000,64'h0,2,1));
    vecs.push_back(mk(0,0,3'b000,32'h5001,64'h0,64'h0000_8000,0,0, 0,0,64'hFFFF_FF80,8'h2,32'h5000,64'h0,2,1));
    vecs.push_back(mk(0,0,3'b010,32'h6000,64'h0,64'h0,1,1, 1,5,64'h0,8'hF,32'h6000,64'h0,3,2));
    vecs.push_back(mk(1,0,3'b010,32'h4004,64'h0,64'h8765_4321_0000_0000,0,0, 0,0,64'hFFFF_FFFF_8765_4321,8'hF0,32'h4000,64'h0,2,1));
    vecs.push_back(mk(1,1,3'b001,32'h4006,64'hBEEF,64'h0,0,0, 0,0,64'h0,8'hC0,32'h4000,64'hBEEF_0000_0000_0000,2,1));

    repeat (3) @(negedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      cur = w;
      #1;
      chk($sformatf("reset%0d cyc", w), 64'(o_cyc), 64'd0);
      chk($sformatf("reset%0d stb", w), 64'(o_stb), 64'd0);
      chk($sformatf("reset%0d rsp_valid", w), 64'(o_rv), 64'd0);
      chk($sformatf("reset%0d exc", w), 64'(o_exc), 64'd0);
      chk($sformatf("reset%0d rdata", w), o_rd, 64'd0);
      chk($sformatf("reset%0d sel", w), 64'(o_sel), 64'd0);
      chk($sformatf("reset%0d stall", w), 64'(o_stall), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(vecs[i]);
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset while a load is waiting on the bus.
    @(negedge clk);
    cur = 0; we = 0; f3 = 3'b010; addr = 32'h7000; v0 = 1'b1;
    @(negedge clk);
    #1;
    chk("rstbus cyc_before", 64'(cyc0), 64'd1);
    rst = 1'b1;
    #1;
    chk("rstbus cyc", 64'(cyc0), 64'd0);
    chk("rstbus stb", 64'(stb0), 64'd0);
    chk("rstbus rsp_valid", 64'(rv0), 64'd0);
    v0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    #1;
    chk("rstbus no_rsp", 64'(rv0), 64'd0);
    chk("rstbus idle_cyc", 64'(cyc0), 64'd0);
    rv = mk(0,0,3'b010,32'h7000,64'h0,64'h1234_5678,0,0, 0,0,64'h1234_5678,8'hF,32'h7000,64'h0,2,1);
    run_txn(rv);
    check_vec("rstbus_after", rv);

    // Randomized traffic on both widths, with occasional stray bus responses.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        ack = 1'b1; err = 1'($urandom_range(0, 1));
        @(negedge clk);
        ack = 1'b0; err = 1'b0;
      end
      begin
        int m, which;
        logic [31:0] ra;
        which = $urandom_range(0, 1);
        m = $urandom_range(0, 9);
        m = (m < 6) ? 0 : (m < 8) ? 1 : (m == 8) ? 2 : 3;
        ra = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
        rv = model(which, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra,
                   {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, (which != 0) ? TO1 + 1 : TO0 + 1), m);
      end
      run_txn(rv);
      check_vec($sformatf("rnd%0d", i), rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
